// File: rtl/fbw_defs_pkg.sv
// Shared definitions for the frame buffer writer: FSM encoding, frame size default,
// RGB565 field layout and luma coefficients.
package fbw_defs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fbw_state_e;

  localparam int FBW_FRAME_PIXELS = 19200;

  // RGB565 field positions, high byte first on the wire
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam logic [7:0] LUMA_CR = 8'd77;
  localparam logic [7:0] LUMA_CG = 8'd150;
  localparam logic [7:0] LUMA_CB = 8'd29;

endpackage

// File: rtl/rgb565_to_luma.sv
// Combinational RGB565 -> 8-bit luma; channels are bit-replicated to 8 bits and
// weighted so the coefficients sum to 256 (white maps exactly to 255).
module rgb565_to_luma
  import fbw_defs_pkg::*;
(
  input  logic [15:0] pix_i,
  output logic [7:0]  luma_o
);

  rgb565_t     px;
  logic [7:0]  r8, g8, b8;
  logic [15:0] acc;

  assign px = rgb565_t'(pix_i);
  assign r8 = {px.r, px.r[4:2]};
  assign g8 = {px.g, px.g[5:4]};
  assign b8 = {px.b, px.b[4:2]};

  // Max sum is 256*255, so the 16-bit intermediate never overflows
  assign acc = 16'(LUMA_CR) * 16'(r8) + 16'(LUMA_CG) * 16'(g8) + 16'(LUMA_CB) * 16'(b8);
  assign luma_o = 8'(acc >> 8);

endmodule

// File: rtl/frame_buffer_writer.sv
// Fills the BRAM frame buffer from a sof-delimited byte stream.
// FBW_GRAY_CONVERT_EN: input is RGB565 (2 bytes/pixel) converted to grey; otherwise 1 byte = 1 grey pixel.
module frame_buffer_writer
  import fbw_defs_pkg::*;
#(
  parameter int FRAME_PIXELS = FBW_FRAME_PIXELS,
  parameter int ADDR_W       = 15,
  parameter int ERR_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  input  logic              freeze,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [7:0]        bram_wdata,
  output logic              frame_done,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

  fbw_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d, cur_idx;
  logic              we_q, we_d, done_q, done_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              acc, start, pix_done;
  logic [7:0]        pix_val;

  // Ready is forced low while reset is held, independent of the clock
  assign s_ready = rst_n && ((state_q == WRITE) || (state_q == IDLE && !freeze));
  assign acc     = s_valid && s_ready;
  assign start   = acc && s_sof;
  assign cur_idx = start ? '0 : pix_q;

`ifdef FBW_GRAY_CONVERT_EN
  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] luma;

  rgb565_to_luma u_luma (.pix_i({hi_q, s_data}), .luma_o(luma));

  // phase_q=1 means the high byte is held and the next byte completes the pixel
  always_comb begin
    phase_d  = phase_q;
    hi_d     = hi_q;
    pix_done = 1'b0;
    pix_val  = luma;
    if (start) begin
      phase_d = 1'b1;
      hi_d    = s_data;
    end else if (acc && state_q == WRITE) begin
      if (!phase_q) begin
        phase_d = 1'b1;
        hi_d    = s_data;
      end else begin
        phase_d  = 1'b0;
        pix_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end
`else
  assign pix_done = start || (acc && state_q == WRITE);
  assign pix_val  = s_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pix_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WRITE: begin
        if (pix_done && cur_idx == LAST_IDX) state_d = DONE;
        else if (start)                      state_d = WRITE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // frame_done trails DONE by a cycle so it lands after the final write strobe
  always_comb begin
    we_d    = pix_done;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pix_d   = cur_idx;
    if (pix_done) begin
      waddr_d = cur_idx;
      wdata_d = pix_val;
      pix_d   = cur_idx + 1'b1;
    end
    done_d = (state_q == DONE);
    err_d  = err_q;
    if (start && state_q == WRITE && err_q != '1) err_d = err_q + 1'b1;
  end

  assign bram_we    = we_q;
  assign bram_waddr = waddr_q;
  assign bram_wdata = wdata_q;
  assign frame_done = done_q;
  assign busy       = (state_q == WRITE);
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer; expected BRAM writes are queued as bytes are driven.
`timescale 1ns/1ps
module tb_frame_buffer_writer;

  localparam int FP = 1200;   // shortened frame keeps the run brief
  localparam int AW = 11;
  localparam int EW = 2;
  localparam logic [AW-1:0] LAST = AW'(FP - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0, s_sof = 1'b0, freeze = 1'b0;
  logic          s_ready, bram_we, frame_done, busy;
  logic [AW-1:0] bram_waddr;
  logic [7:0]    bram_wdata;
  logic [EW-1:0] err_cnt;

  frame_buffer_writer #(.FRAME_PIXELS(FP), .ADDR_W(AW), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .freeze(freeze), .bram_we(bram_we), .bram_waddr(bram_waddr),
    .bram_wdata(bram_wdata), .frame_done(frame_done), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, done_cnt = 0;
  logic [AW+7:0] exp_q[$];
  logic          prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [AW+7:0] e;
    if (bram_we) begin
      if (exp_q.size() == 0) chk("unexp_wr", 32'(bram_we), 0);
      else begin
        e = exp_q.pop_front();
        chk("waddr", 32'(bram_waddr), 32'(e[AW+7:8]));
        chk("wdata", 32'(bram_wdata), 32'(e[7:0]));
      end
    end
    if (frame_done) begin
      done_cnt++;
      chk("done_after_last", 32'({prev_we, prev_addr}), 32'({1'b1, LAST}));
    end
    prev_we   = bram_we;
    prev_addr = bram_waddr;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
    end
  endtask

  // Presents one byte and returns just after the edge that accepted it
  task automatic send(input logic [7:0] d, input logic sof);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (s_ready) begin
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("ready_timeout", 32'(s_ready), 1);
  endtask

  task automatic frame(input int n, input int gap_pct, input int frz_at);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle($urandom_range(3, 1));
      if (i == frz_at) freeze = 1'b1;
      exp_q.push_back({AW'(i), 8'(i)});
      send(8'(i), i == 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    logic [15:0] px [5];
    logic [7:0]  ly [5];
    px = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h0000};
    ly = '{8'd255, 8'd76, 8'd149, 8'd28, 8'd0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_we", 32'(bram_we), 0);
    chk("rst_waddr", 32'(bram_waddr), 0);
    chk("rst_wdata", 32'(bram_wdata), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_ready", 32'(s_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FBW_GRAY_CONVERT_EN
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({AW'(k), ly[k]});
      send(px[k][15:8], k == 0);
      send(px[k][7:0], 1'b0);
    end
    idle(4);
    chk("t5_q", exp_q.size(), 0);
    chk("t5_busy", 32'(busy), 1);
`else
    // full gap-free frame
    d0 = done_cnt;
    frame(FP, 0, -1);
    #1 chk("t1_done_state_ready", 32'(s_ready), 0);
    idle(4);
    chk("t1_ndone", done_cnt - d0, 1);
    chk("t1_q", exp_q.size(), 0);

    // abort after 100 bytes, restart with a full frame
    d0 = done_cnt;
    frame(100, 0, -1);
    #1 chk("t2_busy", 32'(busy), 1);
    chk("t2_err0", 32'(err_cnt), 0);
    frame(FP, 0, -1);
    idle(4);
    chk("t2_err1", 32'(err_cnt), 1);
    chk("t2_ndone", done_cnt - d0, 1);
    chk("t2_q", exp_q.size(), 0);

    // repeated aborts saturate the counter
    d0 = done_cnt;
    repeat (4) frame(5, 0, -1);
    frame(FP, 0, -1);
    idle(4);
    chk("sat_err", 32'(err_cnt), 3);
    chk("sat_ndone", done_cnt - d0, 1);

    // freeze in IDLE blocks sof; freeze raised mid-frame is ignored
    d0 = done_cnt;
    @(negedge clk);
    freeze = 1'b1; s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h5A;
    repeat (4) begin
      #1 chk("t3_frz_ready", 32'(s_ready), 0);
      @(negedge clk);
    end
    s_valid = 1'b0; s_sof = 1'b0; freeze = 1'b0;
    chk("t3_frz_nodone", done_cnt - d0, 0);
    frame(FP, 0, 300);
    idle(4);
    #1 chk("t3_idle_frz_ready", 32'(s_ready), 0);
    chk("t3_ndone", done_cnt - d0, 1);
    chk("t3_q", exp_q.size(), 0);
    freeze = 1'b0;

    // random gaps, then trailing non-sof bytes must be dropped
    d0 = done_cnt;
    frame(FP, 30, -1);
    repeat (5) send(8'hA5, 1'b0);
    idle(4);
    chk("t4_ndone", done_cnt - d0, 1);
    chk("t4_q", exp_q.size(), 0);
    chk("t4_busy", 32'(busy), 0);

    // async reset mid-frame
    frame(500, 0, -1);
    idle(2);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_q", exp_q.size(), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we", 32'(bram_we), 0);
    chk("t6_waddr", 32'(bram_waddr), 0);
    chk("t6_wdata", 32'(bram_wdata), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_err_rst", 32'(err_cnt), 0);
    chk("t6_ready_rst", 32'(s_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    frame(FP, 0, -1);
    idle(4);
    chk("t6_ndone", done_cnt - d0, 1);
    chk("t6_err", 32'(err_cnt), 0);
    chk("t6_q_end", exp_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
